// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, left-aligned unit patterns and scheduler states.
package morse_pkg;

    localparam int MORSE_PAT_W    = 14;
    localparam int TICK_DIV_50MHZ = 25_000_000;

    typedef logic [2:0] letter_t;

    localparam letter_t LTR_S = 3'd0;
    localparam letter_t LTR_T = 3'd1;
    localparam letter_t LTR_U = 3'd2;
    localparam letter_t LTR_V = 3'd3;
    localparam letter_t LTR_W = 3'd4;
    localparam letter_t LTR_X = 3'd5;
    localparam letter_t LTR_Y = 3'd6;
    localparam letter_t LTR_Z = 3'd7;

    // One bit per unit, MSB sent first; listed Z (index 7) down to S (index 0).
    localparam logic [7:0][MORSE_PAT_W-1:0] MORSE_LUT = {
        14'b11101110101000,
        14'b11101011101110,
        14'b11101010111000,
        14'b10111011100000,
        14'b10101011100000,
        14'b10101110000000,
        14'b11100000000000,
        14'b10101000000000
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

endpackage

// File: rtl/morse_message_scheduler_if.sv
// Letter-in / Morse-out bundle of the scheduler; the scheduler is the slave side.
interface morse_message_scheduler_if;
    import morse_pkg::*;

    logic       in_valid;
    letter_t    in_letter;
    logic       in_ready;
    logic       abort;
    logic       morse_out;
    logic       busy;
    logic       letter_done;
    logic [2:0] fifo_count;

    modport master (
        output in_valid, in_letter, abort,
        input  in_ready, morse_out, busy, letter_done, fifo_count
    );

    modport slave (
        input  in_valid, in_letter, abort,
        output in_ready, morse_out, busy, letter_done, fifo_count
    );

endinterface

// File: rtl/morse_unit_divider.sv
// Unit-rate divider: tick on the last of every TICK_DIV running cycles, no latency beyond the count.
// No backpressure; holds its count while run is low, reload wins over run.
module morse_unit_divider
    import morse_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic reload,
    output logic tick
);

    localparam int            CW  = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            cnt <= TOP;
        end else if (run) begin
            cnt <= (cnt == '0) ? TOP : cnt - CW'(1);
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/morse_message_scheduler.sv
// Queues letters S..Z and keys them out as Morse, GAP_UNITS low units after each; first unit 3 cycles after accept.
// Backpressure: in_ready drops when the 4-entry queue is full or abort is held; no bypass when full.
module morse_message_scheduler
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_50MHZ,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UNITS  = 3,
    parameter int PAT_W      = MORSE_PAT_W
) (
    input  logic                      mc_clock,
    input  logic                      mc_reset,
    morse_message_scheduler_if.slave  bus
);

    localparam int         PW    = $clog2(FIFO_DEPTH);
    localparam int         GW    = (GAP_UNITS > 1) ? $clog2(GAP_UNITS + 1) : 1;
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    state_t           state, state_nxt;
    letter_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic [PAT_W-1:0] shreg, shreg_nxt, shifted;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic             push, pop, tick, done, run, reload, morse_bit;

    assign bus.in_ready    = (count < DEPTH) && !bus.abort;
    assign push            = bus.in_valid && bus.in_ready;
    assign bus.fifo_count  = count;
    assign bus.busy        = (state != ST_IDLE) || (count != '0);
    assign bus.letter_done = done;
    assign bus.morse_out   = morse_bit;

    assign run    = (state == ST_SEND) || (state == ST_GAP);
    assign reload = (state == ST_LOAD) || bus.abort;

    morse_unit_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk    (mc_clock),
        .rst    (mc_reset),
        .run    (run),
        .reload (reload),
        .tick   (tick)
    );

    always_ff @(posedge mc_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.in_letter;
        end
    end

    always_ff @(posedge mc_clock) begin
        if (mc_reset || bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
        end
    end

    always_ff @(posedge mc_clock) begin
        if (mc_reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        done      = 1'b0;
        morse_bit = 1'b0;
        shifted   = {shreg[PAT_W-2:0], 1'b0};

        case (state)
            ST_IDLE: begin
                if (count != '0) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                pop       = 1'b1;
                shreg_nxt = MORSE_LUT[fifo_mem[rd_ptr]];
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                morse_bit = shreg[PAT_W-1];
                if (tick) begin
                    shreg_nxt = shifted;
                    // Trailing zeros are never keyed: the letter ends with its last lit unit.
                    if (shifted == '0) begin
                        if (GAP_UNITS > 0) begin
                            state_nxt = ST_GAP;
                            gap_nxt   = GW'(GAP_UNITS);
                        end else begin
                            done      = 1'b1;
                            state_nxt = (count != '0) ? ST_LOAD : ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt == GW'(1)) begin
                        done      = 1'b1;
                        state_nxt = (count != '0) ? ST_LOAD : ST_IDLE;
                    end else begin
                        gap_nxt = gap_cnt - GW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort drops the letter in flight without reporting it as done.
        if (bus.abort) begin
            state_nxt = ST_IDLE;
            shreg_nxt = '0;
            gap_nxt   = '0;
            pop       = 1'b0;
            done      = 1'b0;
        end
    end

endmodule
